// File: rtl/conv_stream_ctrl.sv
// Per-sample sequencer that feeds a 3-tap complex convolution engine and registers its results.
// Latency: a sample accepted at edge k drives eng_win after k, and its result is valid after edge k+1.
// Backpressure: at most one result waits in the window; when it cannot be captured, in_ready drops.
module conv_stream_ctrl #(
  parameter int  QI        = 3,
  parameter int  QF        = 3,
  parameter int  NUM_ELEMS = 100,
  localparam int W         = QI + QF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [6*W-1:0]      kernel,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [W-1:0] in_re,
  input  logic signed [W-1:0] in_im,
  output logic [6*W-1:0]      eng_win,
  output logic [6*W-1:0]      eng_kernel,
  input  logic signed [W-1:0] eng_y_re,
  input  logic signed [W-1:0] eng_y_im,
  input  logic                eng_ovf,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [W-1:0] out_re,
  output logic signed [W-1:0] out_im,
  output logic                out_last,
  output logic                busy,
  output logic                done,
  output logic                overflow
);

  // Counters must reach NUM_ELEMS+2: the input counter also counts the two zero flush steps.
  localparam int CW = $clog2(NUM_ELEMS + 3);
  localparam logic [CW-1:0] LAST_IN    = CW'(NUM_ELEMS - 1);
  localparam logic [CW-1:0] LAST_FLUSH = CW'(NUM_ELEMS + 1);
  localparam logic [CW-1:0] LAST_OUT   = CW'(NUM_ELEMS + 1);

  typedef struct packed {
    logic [W-1:0] re;
    logic [W-1:0] im;
  } cplx_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_FLUSH = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t          state;
  state_t          state_nxt;

  // win[0] is the newest sample, win[2] the oldest.
  cplx_t [2:0]     win;
  logic            wv;
  logic [CW-1:0]   in_cnt;
  logic [CW-1:0]   out_cnt;
  logic [6*W-1:0]  kern_q;

  logic            cap;
  logic            step_ok;
  logic            step;
  logic            out_hs;
  logic            job_start;
  cplx_t           new_sample;

  // A pending window result is captured when the output slot is free or being emptied.
  assign cap       = wv && (!out_valid || out_ready);
  // The window may only advance when its current result is not still waiting.
  assign step_ok   = !wv || cap;
  assign out_hs    = out_valid && out_ready;
  assign job_start = (state == S_IDLE) && start;

  assign eng_win    = {win[0], win[1], win[2]};
  assign eng_kernel = kern_q;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: fill with NUM_ELEMS samples, push two zeros, then wait for the last handshake.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_FILL;
      end
      S_FILL: begin
        if (step && (in_cnt == LAST_IN)) state_nxt = S_FLUSH;
      end
      S_FLUSH: begin
        if (step && (in_cnt == LAST_FLUSH)) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (out_hs && out_last) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State-decoded outputs: input handshake, window step and the sample shifted in.
  always_comb begin
    in_ready   = 1'b0;
    busy       = 1'b1;
    step       = 1'b0;
    new_sample = '0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
      end
      S_FILL: begin
        in_ready   = step_ok;
        step       = in_valid && step_ok;
        new_sample = '{re: in_re, im: in_im};
      end
      S_FLUSH: begin
        step = step_ok;
      end
      default: begin
      end
    endcase
  end

  // Window, counters, latched kernel and sticky overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win      <= '0;
      wv       <= 1'b0;
      in_cnt   <= '0;
      out_cnt  <= '0;
      kern_q   <= '0;
      overflow <= 1'b0;
    end else if (job_start) begin
      win      <= '0;
      wv       <= 1'b0;
      in_cnt   <= '0;
      out_cnt  <= '0;
      kern_q   <= kernel;
      overflow <= 1'b0;
    end else begin
      if (step) begin
        win    <= {win[1], win[0], new_sample};
        in_cnt <= in_cnt + 1'b1;
      end
      // A step in the same cycle as a capture leaves a fresh result pending.
      if (step) begin
        wv <= 1'b1;
      end else if (cap) begin
        wv <= 1'b0;
      end
      if (cap) begin
        out_cnt  <= out_cnt + 1'b1;
        overflow <= overflow | eng_ovf;
      end
    end
  end

  // Output register: loads on capture, holds while stalled, empties on a bare handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_re    <= '0;
      out_im    <= '0;
      out_last  <= 1'b0;
    end else if (cap) begin
      out_valid <= 1'b1;
      out_re    <= eng_y_re;
      out_im    <= eng_y_im;
      out_last  <= (out_cnt == LAST_OUT);
    end else if (out_ready) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end

  // Job completion pulse, one cycle after the final output handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done <= 1'b0;
    end else begin
      done <= (state == S_DRAIN) && out_hs && out_last;
    end
  end

endmodule

// File: tb/tb_conv_stream_ctrl.sv
// Bench for conv_stream_ctrl with a behavioural complex engine attached (products and sum wrap, flagging overflow).
// Table vectors, hand-written control sequences and randomized jobs against a convolution reference.
// Outputs are sampled at the falling edge, inputs driven there too; every wait is cycle-bounded.
`timescale 1ns/1ps
module tb_conv_stream_ctrl;
  localparam int QI   = 3;
  localparam int QF   = 3;
  localparam int W    = QI + QF;
  localparam int NE   = 4;
  localparam int NO   = NE + 2;
  localparam int MAXV = (1 << (W - 1)) - 1;
  localparam int MINV = -(1 << (W - 1));

  typedef logic [NE-1:0][W-1:0] xs_t;
  typedef logic [NO-1:0][W-1:0] ys_t;
  typedef struct packed {
    logic [6*W-1:0] k;
    xs_t            xr;
    xs_t            xi;
    ys_t            er;
    ys_t            ei;
    logic           ovf;
  } vec_t;

  logic                clk = 1'b0;
  logic                rst, start, in_valid, in_ready, out_valid, out_ready;
  logic [6*W-1:0]      kernel, eng_win, eng_kernel;
  logic signed [W-1:0] in_re, in_im, eng_y_re, eng_y_im, out_re, out_im;
  logic                eng_ovf, out_last, busy, done, overflow;

  always #5 clk = ~clk;

  conv_stream_ctrl #(.QI(QI), .QF(QF), .NUM_ELEMS(NE)) dut (
    .clk(clk), .rst(rst), .start(start), .kernel(kernel),
    .in_valid(in_valid), .in_ready(in_ready), .in_re(in_re), .in_im(in_im),
    .eng_win(eng_win), .eng_kernel(eng_kernel),
    .eng_y_re(eng_y_re), .eng_y_im(eng_y_im), .eng_ovf(eng_ovf),
    .out_valid(out_valid), .out_ready(out_ready), .out_re(out_re), .out_im(out_im),
    .out_last(out_last), .busy(busy), .done(done), .overflow(overflow)
  );

  int n_cmp = 0;
  int n_bad = 0;

  function automatic int wrapw(input int v);
    logic [W-1:0] t;
    t = v[W-1:0];
    return int'($signed(t));
  endfunction

  function automatic int fld(input logic [6*W-1:0] v, input int i);
    logic [W-1:0] t;
    t = v[6*W-1-i*W -: W];
    return int'($signed(t));
  endfunction

  function automatic logic [6*W-1:0] pack_k(input int a, b, c, d, e, f);
    return {W'(a), W'(b), W'(c), W'(d), W'(e), W'(f)};
  endfunction

  function automatic xs_t mk4(input int a, b, c, d);
    xs_t r;
    r[0] = W'(a); r[1] = W'(b); r[2] = W'(c); r[3] = W'(d);
    return r;
  endfunction

  function automatic ys_t mk6(input int a, b, c, d, e, f);
    ys_t r;
    r[0] = W'(a); r[1] = W'(b); r[2] = W'(c); r[3] = W'(d); r[4] = W'(e); r[5] = W'(f);
    return r;
  endfunction

  // Fixed-point complex multiply: full product scaled by 2^-QF, wrapped to W bits.
  function automatic void cmul(input int ar, ai, br, bi, output int pr, pi, output bit ov);
    pr = (ar * br - ai * bi) >>> QF;
    pi = (ar * bi + ai * br) >>> QF;
    ov = (pr > MAXV) || (pr < MINV) || (pi > MAXV) || (pi < MINV);
    pr = wrapw(pr);
    pi = wrapw(pi);
  endfunction

  // Attached engine: k0*x0 + k1*x1 + k2*x2 on whatever the controller presents.
  int e_pr, e_pi, e_sr, e_si;
  bit e_ov, e_any;
  always_comb begin
    e_pr = 0; e_pi = 0; e_sr = 0; e_si = 0; e_ov = 1'b0; e_any = 1'b0;
    for (int j = 0; j < 3; j++) begin
      cmul(fld(eng_kernel, 2*j), fld(eng_kernel, 2*j+1), fld(eng_win, 2*j), fld(eng_win, 2*j+1),
           e_pr, e_pi, e_ov);
      e_sr  = e_sr + e_pr;
      e_si  = e_si + e_pi;
      e_any = e_any | e_ov;
    end
    e_any    = e_any || (e_sr > MAXV) || (e_sr < MINV) || (e_si > MAXV) || (e_si < MINV);
    eng_y_re = W'(e_sr);
    eng_y_im = W'(e_si);
    eng_ovf  = e_any;
  end

  // Job stimulus, expectations and collected results.
  int xr_a[NE], xi_a[NE], exp_re[NO], exp_im[NO];
  bit exp_ovf;
  int got_re[$], got_im[$];
  bit got_last[$];
  int done_cyc;
  bit ovf_at_done, busy_at_done, aborted;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Reference: full linear convolution y[n] = sum_j k_j * x[n-j], x zero outside the job.
  task automatic ref_conv(input logic [6*W-1:0] k);
    int sr, si, pr, pi, xr, xi, m;
    bit ov;
    exp_ovf = 1'b0;
    for (int n = 0; n < NO; n++) begin
      sr = 0; si = 0;
      for (int j = 0; j < 3; j++) begin
        m  = n - j;
        xr = (m >= 0 && m < NE) ? xr_a[m] : 0;
        xi = (m >= 0 && m < NE) ? xi_a[m] : 0;
        cmul(fld(k, 2*j), fld(k, 2*j+1), xr, xi, pr, pi, ov);
        sr = sr + pr; si = si + pi;
        exp_ovf = exp_ovf | ov;
      end
      exp_ovf   = exp_ovf || (sr > MAXV) || (sr < MINV) || (si > MAXV) || (si < MINV);
      exp_re[n] = wrapw(sr);
      exp_im[n] = wrapw(si);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, " in_ready"},  int'(in_ready),  0);
    check({tag, " out_valid"}, int'(out_valid), 0);
    check({tag, " out_last"},  int'(out_last),  0);
    check({tag, " busy"},      int'(busy),      0);
    check({tag, " done"},      int'(done),      0);
    check({tag, " overflow"},  int'(overflow),  0);
    check({tag, " out_re"},    int'(out_re),    0);
    check({tag, " out_im"},    int'(out_im),    0);
    check({tag, " eng_win_zero"},    int'(eng_win == '0),    1);
    check({tag, " eng_kernel_zero"}, int'(eng_kernel == '0), 1);
  endtask

  // Runs one job. start_at pulses start mid-job, abort_at raises rst at that cycle,
  // stall_len holds out_ready low that many cycles from the first out_valid.
  task automatic run_job(input logic [6*W-1:0] k, input int vprob, input int rprob,
                         input int stall_len, input int start_at, input int abort_at,
                         input string tag);
    int idx, stall_left, stall_i, prev_re, prev_im;
    bit stalled_prev, seen_valid, prev_last;
    idx = 0; stall_left = 0; stall_i = 0; stalled_prev = 0; seen_valid = 0;
    prev_re = 0; prev_im = 0; prev_last = 0;
    got_re.delete(); got_im.delete(); got_last.delete();
    done_cyc = -1; aborted = 0;
    @(negedge clk);
    kernel = k; start = 1'b1;
    in_valid = 1'b1; in_re = W'(31); in_im = W'(-5);  // must not be taken: in_ready is 0 in IDLE
    out_ready = 1'b1;
    for (int it = 0; it < 400; it++) begin
      @(negedge clk);
      start = (it == start_at);
      if (start) kernel = ~k;
      if (it == 0) begin
        check({tag, " ovf_clear_at_start"}, int'(overflow), 0);
        check({tag, " busy_after_start"}, int'(busy), 1);
      end
      if (done) begin
        done_cyc = it; ovf_at_done = overflow; busy_at_done = busy;
        break;
      end
      if (it == abort_at) begin
        check({tag, " busy_before_abort"}, int'(busy), 1);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check_zero({tag, " abort"});
        rst = 1'b0;
        aborted = 1;
        break;
      end
      if (stalled_prev) begin
        check({tag, " hold_valid"}, int'(out_valid), 1);
        check({tag, " hold_re"}, int'(out_re), prev_re);
        check({tag, " hold_im"}, int'(out_im), prev_im);
        check({tag, " hold_last"}, int'(out_last), int'(prev_last));
      end
      if (stall_len > 0 && !seen_valid && out_valid) begin
        seen_valid = 1; stall_left = stall_len;
      end
      if (stall_left > 0) begin
        out_ready = 1'b0; stall_left--; stall_i++;
      end else begin
        out_ready = ($urandom_range(0, 99) < rprob);
      end
      in_valid = (idx < NE) && ($urandom_range(0, 99) < vprob);
      in_re = (idx < NE) ? W'(xr_a[idx]) : '0;
      in_im = (idx < NE) ? W'(xi_a[idx]) : '0;
      #1;
      if (stall_i == 2 && !out_ready) check({tag, " in_ready_drop"}, int'(in_ready), 0);
      if (in_valid && in_ready) idx++;
      if (out_valid && out_ready) begin
        got_re.push_back(int'(out_re));
        got_im.push_back(int'(out_im));
        got_last.push_back(out_last);
      end
      stalled_prev = out_valid && !out_ready;
      prev_re = int'(out_re); prev_im = int'(out_im); prev_last = out_last;
    end
    start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    if (!aborted) begin
      check({tag, " done_seen"}, int'(done_cyc >= 0), 1);
      if (done_cyc >= 0) begin
        @(negedge clk);
        check({tag, " done_one_cycle"}, int'(done), 0);
      end
    end
  endtask

  task automatic check_job(input string tag, input bit timing);
    int n;
    check({tag, " out_count"}, got_re.size(), NO);
    n = (got_re.size() < NO) ? got_re.size() : NO;
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s y%0d_re", tag, i), got_re[i], exp_re[i]);
      check($sformatf("%s y%0d_im", tag, i), got_im[i], exp_im[i]);
      check($sformatf("%s y%0d_last", tag, i), int'(got_last[i]), int'(i == NO - 1));
    end
    check({tag, " ovf_at_done"}, int'(ovf_at_done), int'(exp_ovf));
    check({tag, " busy_at_done"}, int'(busy_at_done), 0);
    if (timing) check({tag, " start_to_done"}, done_cyc, NE + 4);
  endtask

  task automatic load_row(input vec_t v);
    for (int i = 0; i < NE; i++) begin
      xr_a[i] = int'($signed(v.xr[i]));
      xi_a[i] = int'($signed(v.xi[i]));
    end
    for (int i = 0; i < NO; i++) begin
      exp_re[i] = int'($signed(v.er[i]));
      exp_im[i] = int'($signed(v.ei[i]));
    end
    exp_ovf = v.ovf;
  endtask

  vec_t tbl[4];
  logic [6*W-1:0] rk;

  initial begin
    // Taps of 8 are 1.0; overflow row wraps because the attached engine wraps.
    tbl[0] = '{k: pack_k(8, 0, 8, 0, 8, 0), xr: mk4(4, 4, 4, 4), xi: '0,
               er: mk6(4, 8, 12, 12, 8, 4), ei: '0, ovf: 1'b0};
    tbl[1] = '{k: pack_k(0, 0, 0, 8, 0, 0), xr: mk4(8, 0, 0, 0), xi: '0,
               er: '0, ei: mk6(0, 8, 0, 0, 0, 0), ovf: 1'b0};
    tbl[2] = '{k: pack_k(8, 0, 8, 0, 8, 0), xr: mk4(24, 24, 24, 24), xi: '0,
               er: mk6(24, -16, 8, 8, -16, 24), ei: '0, ovf: 1'b1};
    tbl[3] = tbl[0];

    rst = 1'b1; start = 1'b0; kernel = '0; in_valid = 1'b0; in_re = '0; in_im = '0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;

    for (int r = 0; r < 4; r++) begin
      load_row(tbl[r]);
      run_job(tbl[r].k, 100, 100, 0, -1, -1, $sformatf("row%0d", r));
      check_job($sformatf("row%0d", r), 1'b1);
    end

    load_row(tbl[0]);
    run_job(tbl[0].k, 100, 100, 5, -1, -1, "stall");
    check_job("stall", 1'b0);

    load_row(tbl[0]);
    run_job(tbl[0].k, 100, 100, 0, 2, -1, "start_in_fill");
    check_job("start_in_fill", 1'b1);

    load_row(tbl[0]);
    run_job(tbl[0].k, 100, 100, 0, -1, 4, "rst_flush");
    run_job(tbl[0].k, 100, 100, 0, -1, -1, "after_rst");
    check_job("after_rst", 1'b1);

    for (int j = 0; j < 25; j++) begin
      rk = pack_k(int'($urandom_range(0, 16)) - 8, int'($urandom_range(0, 16)) - 8,
                  int'($urandom_range(0, 16)) - 8, int'($urandom_range(0, 16)) - 8,
                  int'($urandom_range(0, 16)) - 8, int'($urandom_range(0, 16)) - 8);
      for (int i = 0; i < NE; i++) begin
        xr_a[i] = int'($urandom_range(0, 32)) - 16;
        xi_a[i] = int'($urandom_range(0, 32)) - 16;
      end
      ref_conv(rk);
      run_job(rk, int'($urandom_range(30, 100)), int'($urandom_range(30, 100)), 0, -1, -1,
              $sformatf("rand%0d", j));
      check_job($sformatf("rand%0d", j), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
